// File: rtl/capture_pkg.sv
// Shared state encoding and arithmetic helpers for the BCD operand capture front end.
package capture_pkg;

    typedef enum logic [1:0] {
        S_OP1,
        S_OP2,
        S_VALID,
        S_ERR
    } state_t;

    localparam logic [3:0] MAX_BCD  = 4'd9;
    localparam int         HELPER_W = 32;

    function automatic logic [HELPER_W-1:0] mul10_add(input logic [HELPER_W-1:0] mag,
                                                      input logic [3:0]          d);
        return (mag << 3) + (mag << 1) + {{(HELPER_W-4){1'b0}}, d};
    endfunction

    // Negating zero gives zero, so a "-0" operand naturally comes out as 0.
    function automatic logic [HELPER_W-1:0] to_twos(input logic                sign,
                                                    input logic [HELPER_W-1:0] mag);
        return sign ? -mag : mag;
    endfunction

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

endpackage

// File: rtl/bcd_accumulator.sv
// Digit counter, running magnitude and sign latch shared by both operands.
module bcd_accumulator
    import capture_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int OUT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_accept,
    input  logic             i_clear,
    input  logic [3:0]       i_digit,
    input  logic             i_sign,
    output logic             o_last_digit,
    output logic             o_bad_digit,
    output logic [OUT_W-1:0] o_value_next
);

    localparam int MAG_W = OUT_W - 1;
    localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]    r_count;
    logic [MAG_W-1:0]    r_mag;
    logic                r_sign;
    logic [HELPER_W-1:0] w_magNext;
    logic                w_first;
    logic                w_sign;

    // The first digit's sign must already apply when it is also the last digit.
    assign w_first      = (r_count == '0);
    assign w_sign       = w_first ? i_sign : r_sign;
    assign w_magNext    = mul10_add(HELPER_W'(r_mag), i_digit);
    assign o_last_digit = (r_count == LAST_IDX);
    assign o_bad_digit  = (i_digit > MAX_BCD);
    assign o_value_next = OUT_W'(to_twos(w_sign, w_magNext));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_mag   <= '0;
            r_sign  <= 1'b0;
        end else if (i_clear) begin
            r_count <= '0;
            r_mag   <= '0;
            r_sign  <= 1'b0;
        end else if (i_accept) begin
            if (w_first) r_sign <= i_sign;
            if (o_bad_digit || o_last_digit) begin
                r_count <= '0;
                r_mag   <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
                r_mag   <= MAG_W'(w_magNext);
            end
        end
    end

endmodule

// File: rtl/module_operand_capture.sv
// Assembles two signed BCD operands from a digit stream and hands them over with valid/ack.
module module_operand_capture
    import capture_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int OUT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dat_ready,
    input  logic [3:0]       dato,
    input  logic             signo,
    input  logic             clear,
    input  logic             ack,
    output logic [OUT_W-1:0] numero1_o,
    output logic [OUT_W-1:0] numero2_o,
    output logic             valid,
    output logic             error_o,
    output logic             op_sel_o
);

    if (NUM_DIGITS < 1 || OUT_W > HELPER_W ||
        ((longint'(1) << (OUT_W - 1)) - 1) < (pow10(NUM_DIGITS) - 1)) begin : g_bad_config
        $error("module_operand_capture: OUT_W too small for NUM_DIGITS");
    end

    state_t           r_state;
    state_t           w_stateNext;
    logic             r_rdyQ;
    logic [OUT_W-1:0] r_num1;
    logic [OUT_W-1:0] r_num2;
    logic             w_edge;
    logic             w_accept;
    logic             w_last;
    logic             w_bad;
    logic             w_complete;
    logic [OUT_W-1:0] w_value;

    assign w_edge     = dat_ready & ~r_rdyQ;
    assign w_accept   = w_edge & ~clear & ((r_state == S_OP1) || (r_state == S_OP2));
    assign w_complete = w_accept & ~w_bad & w_last;
    assign numero1_o  = r_num1;
    assign numero2_o  = r_num2;

    bcd_accumulator #(
        .NUM_DIGITS (NUM_DIGITS),
        .OUT_W      (OUT_W)
    ) u_acc (
        .clk          (clk),
        .rst          (rst),
        .i_accept     (w_accept),
        .i_clear      (clear),
        .i_digit      (dato),
        .i_sign       (signo),
        .o_last_digit (w_last),
        .o_bad_digit  (w_bad),
        .o_value_next (w_value)
    );

    // rdy_q comes out of reset high so a strobe already high at release is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_OP1;
            r_rdyQ  <= 1'b1;
        end else begin
            r_state <= w_stateNext;
            r_rdyQ  <= dat_ready;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        if (clear) begin
            w_stateNext = S_OP1;
        end else begin
            case (r_state)
                S_OP1: begin
                    if (w_accept && w_bad)       w_stateNext = S_ERR;
                    else if (w_accept && w_last) w_stateNext = S_OP2;
                end
                S_OP2: begin
                    if (w_accept && w_bad)       w_stateNext = S_ERR;
                    else if (w_accept && w_last) w_stateNext = S_VALID;
                end
                S_VALID: begin
                    if (ack) w_stateNext = S_OP1;
                end
                S_ERR:   w_stateNext = S_ERR;
                default: w_stateNext = S_OP1;
            endcase
        end
        valid    = (r_state == S_VALID);
        error_o  = (r_state == S_ERR);
        op_sel_o = (r_state == S_OP2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num1 <= '0;
            r_num2 <= '0;
        end else if (clear) begin
            r_num1 <= '0;
            r_num2 <= '0;
        end else if (w_complete) begin
            if (r_state == S_OP1) r_num1 <= w_value;
            else                  r_num2 <= w_value;
        end
    end

endmodule

// File: tb/tb_module_operand_capture.sv
// Table-driven bench with a result scoreboard for the BCD operand capture block.
module tb_module_operand_capture;

    typedef struct {
        logic [3:0] d0, d1, d2, d3;
        logic       s1, s2;
        logic [7:0] exp1, exp2;
    } vector_t;

    typedef struct {
        logic [7:0] n1, n2;
    } result_t;

    localparam int NVEC = 6;

    logic        clk;
    logic        rst;
    logic        datReady, signo, clear, ack;
    logic [3:0]  dato;
    logic [7:0]  numero1, numero2;
    logic        valid, errorO, opSel;

    logic        wDatReady, wSigno, wClear, wAck;
    logic [3:0]  wDato;
    logic [10:0] wNum1, wNum2;
    logic        wValid, wError, wOpSel;

    int          checks   = 0;
    int          failures = 0;
    vector_t     vecs [NVEC];
    result_t     expQ [$];

    module_operand_capture #(.NUM_DIGITS(2), .OUT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .dat_ready (datReady),
        .dato      (dato),
        .signo     (signo),
        .clear     (clear),
        .ack       (ack),
        .numero1_o (numero1),
        .numero2_o (numero2),
        .valid     (valid),
        .error_o   (errorO),
        .op_sel_o  (opSel)
    );

    module_operand_capture #(.NUM_DIGITS(3), .OUT_W(11)) dutWide (
        .clk       (clk),
        .rst       (rst),
        .dat_ready (wDatReady),
        .dato      (wDato),
        .signo     (wSigno),
        .clear     (wClear),
        .ack       (wAck),
        .numero1_o (wNum1),
        .numero2_o (wNum2),
        .valid     (wValid),
        .error_o   (wError),
        .op_sel_o  (wOpSel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Strobe held high for highCycles clocks, then low for one.
    task automatic sendDigit(input bit wide, input logic [3:0] d, input logic s, input int highCycles);
        @(negedge clk);
        if (wide) begin
            wDatReady = 1'b1; wDato = d; wSigno = s;
        end else begin
            datReady = 1'b1; dato = d; signo = s;
        end
        repeat (highCycles) @(negedge clk);
        datReady  = 1'b0;
        wDatReady = 1'b0;
        @(negedge clk);
    endtask

    task automatic pushExpected(input logic [7:0] n1, input logic [7:0] n2);
        result_t r;
        r.n1 = n1;
        r.n2 = n2;
        expQ.push_back(r);
    endtask

    // Non-first digits carry the opposite sign to show it is ignored.
    task automatic applyStimulus(input vector_t v);
        pushExpected(v.exp1, v.exp2);
        sendDigit(1'b0, v.d0, v.s1, 1);
        sendDigit(1'b0, v.d1, ~v.s1, 1);
        checkOutput("opSelAfterOp1", 32'(opSel), 1);
        checkOutput("numero1AfterOp1", 32'(numero1), 32'(v.exp1));
        sendDigit(1'b0, v.d2, v.s2, 1);
        @(negedge clk);
        datReady = 1'b1; dato = v.d3; signo = ~v.s2;
        checkOutput("validBeforeLast", 32'(valid), 0);
        @(negedge clk);
        checkOutput("validLatency", 32'(valid), 1);
        datReady = 1'b0;
        @(negedge clk);
    endtask

    task automatic collectResult();
        int      waited;
        result_t r;
        waited = 0;
        while (!valid && waited < 12) begin
            @(negedge clk);
            waited++;
        end
        if (!valid) begin
            checks++; failures++;
            $display("[TB] FAIL validTimeout: got valid=0 expected 1");
            expQ.delete();
        end else if (expQ.size() == 0) begin
            checks++; failures++;
            $display("[TB] FAIL scoreboardEmpty: got valid=1 expected no result");
        end else begin
            r = expQ.pop_front();
            checkOutput("scoreNumero1", 32'(numero1), 32'(r.n1));
            checkOutput("scoreNumero2", 32'(numero2), 32'(r.n2));
        end
    endtask

    task automatic ackPulse();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic enterDigits(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                               input logic [3:0] d, input logic [7:0] n1, input logic [7:0] n2);
        pushExpected(n1, n2);
        sendDigit(1'b0, a, 1'b0, 1);
        sendDigit(1'b0, b, 1'b0, 1);
        sendDigit(1'b0, c, 1'b0, 1);
        sendDigit(1'b0, d, 1'b0, 1);
    endtask

    initial begin
        int waited;
        vecs[0] = '{4'd0, 4'd7, 4'd0, 4'd7, 1'b0, 1'b1, 8'h07, 8'hF9};
        vecs[1] = '{4'd0, 4'd0, 4'd4, 4'd2, 1'b1, 1'b0, 8'h00, 8'h2A};
        vecs[2] = '{4'd9, 4'd9, 4'd9, 4'd9, 1'b0, 1'b1, 8'h63, 8'h9D};
        vecs[3] = '{4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0, 8'h0C, 8'h22};
        vecs[4] = '{4'd5, 4'd0, 4'd0, 4'd1, 1'b1, 1'b1, 8'hCE, 8'hFF};
        vecs[5] = '{4'd1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 8'hF6, 8'h00};

        rst = 1'b1; datReady = 1'b0; dato = 4'd0; signo = 1'b0; clear = 1'b0; ack = 1'b0;
        wDatReady = 1'b0; wDato = 4'd0; wSigno = 1'b0; wClear = 1'b0; wAck = 1'b0;
        #1;
        checkOutput("resetNumero1", 32'(numero1), 0);
        checkOutput("resetNumero2", 32'(numero2), 0);
        checkOutput("resetValid", 32'(valid), 0);
        checkOutput("resetError", 32'(errorO), 0);
        checkOutput("resetOpSel", 32'(opSel), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            collectResult();
            ackPulse();
            checkOutput("ackValidDrop", 32'(valid), 0);
            checkOutput("ackOpSel", 32'(opSel), 0);
            checkOutput("retainNumero1", 32'(numero1), 32'(vecs[i].exp1));
            checkOutput("retainNumero2", 32'(numero2), 32'(vecs[i].exp2));
        end

        $display("[TB] illegal digit and clear recovery");
        sendDigit(1'b0, 4'hA, 1'b0, 1);
        checkOutput("errorSet", 32'(errorO), 1);
        for (int i = 0; i < 3; i++) sendDigit(1'b0, 4'd3, 1'b0, 1);
        checkOutput("errorHeld", 32'(errorO), 1);
        checkOutput("errorNumero1", 32'(numero1), 32'hF6);
        checkOutput("errorNumero2", 32'(numero2), 32'h00);
        checkOutput("errorValid", 32'(valid), 0);
        @(negedge clk);
        clear = 1'b1; datReady = 1'b1; dato = 4'd5;
        @(negedge clk);
        clear = 1'b0; datReady = 1'b0;
        checkOutput("clearError", 32'(errorO), 0);
        checkOutput("clearNumero1", 32'(numero1), 0);
        checkOutput("clearNumero2", 32'(numero2), 0);
        enterDigits(4'd1, 4'd2, 4'd3, 4'd4, 8'h0C, 8'h22);
        collectResult();
        ackPulse();

        $display("[TB] long strobe");
        pushExpected(8'h0C, 8'hDE);
        sendDigit(1'b0, 4'd1, 1'b0, 5);
        sendDigit(1'b0, 4'd2, 1'b1, 1);
        sendDigit(1'b0, 4'd3, 1'b1, 1);
        sendDigit(1'b0, 4'd4, 1'b0, 1);
        collectResult();
        ackPulse();

        $display("[TB] strobe held across reset release");
        @(negedge clk);
        rst = 1'b1; datReady = 1'b1; dato = 4'd7;
        #1;
        checkOutput("asyncResetNumero1", 32'(numero1), 0);
        checkOutput("asyncResetNumero2", 32'(numero2), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        datReady = 1'b0;
        enterDigits(4'd1, 4'd2, 4'd3, 4'd4, 8'h0C, 8'h22);
        collectResult();
        ackPulse();

        $display("[TB] reset mid-entry");
        sendDigit(1'b0, 4'd9, 1'b0, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midResetOpSel", 32'(opSel), 0);
        checkOutput("midResetNumero1", 32'(numero1), 0);
        enterDigits(4'd4, 4'd5, 4'd6, 4'd7, 8'h2D, 8'h43);
        collectResult();
        ackPulse();

        $display("[TB] handshake hold and ack with clear");
        enterDigits(4'd1, 4'd2, 4'd3, 4'd4, 8'h0C, 8'h22);
        collectResult();
        for (int i = 0; i < 5; i++) sendDigit(1'b0, 4'd9, 1'b1, 1);
        repeat (10) @(negedge clk);
        checkOutput("holdValid", 32'(valid), 1);
        checkOutput("holdNumero1", 32'(numero1), 32'h0C);
        checkOutput("holdNumero2", 32'(numero2), 32'h22);
        @(negedge clk);
        ack = 1'b1; clear = 1'b1;
        @(negedge clk);
        ack = 1'b0; clear = 1'b0;
        checkOutput("ackClearValid", 32'(valid), 0);
        checkOutput("ackClearNumero1", 32'(numero1), 0);
        checkOutput("ackClearNumero2", 32'(numero2), 0);
        checkOutput("ackClearOpSel", 32'(opSel), 0);
        enterDigits(4'd0, 4'd1, 4'd0, 4'd2, 8'h01, 8'h02);
        collectResult();
        ackPulse();

        $display("[TB] wide configuration");
        sendDigit(1'b1, 4'd9, 1'b1, 1);
        sendDigit(1'b1, 4'd9, 1'b0, 1);
        sendDigit(1'b1, 4'd9, 1'b0, 1);
        sendDigit(1'b1, 4'd9, 1'b0, 1);
        sendDigit(1'b1, 4'd9, 1'b1, 1);
        sendDigit(1'b1, 4'd9, 1'b1, 1);
        waited = 0;
        while (!wValid && waited < 12) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("wideValid", 32'(wValid), 1);
        checkOutput("wideNumero1", 32'(wNum1), 32'h419);
        checkOutput("wideNumero2", 32'(wNum2), 32'h3E7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
